// File: rtl/img_pkg.sv
// Shared image-streaming constants, FSM state type and pixel beat layout
// for the frame transmitter and its skid FIFO.
package img_pkg;

    localparam int unsigned IMG_W     = 256;
    localparam int unsigned IMG_H     = 256;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned ADDR_W    = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              line_end;
        logic              frame_end;
    } pix_beat_t;

endpackage

// File: rtl/frame_pixel_sender_if.sv
// Valid/ready pixel stream with line-end and frame-end sideband flags.
interface frame_pixel_sender_if #(
    parameter int unsigned DATA_W = img_pkg::DATA_W
);

    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_line_end;
    logic              pix_frame_end;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_line_end,
        output pix_frame_end,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_line_end,
        input  pix_frame_end,
        output pix_ready
    );

endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry register FIFO of pixel beats; slot0 is always the head.
module pix_skid_fifo
    import img_pkg::*;
#(
    parameter type beat_t = pix_beat_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head_beat,
    output logic       empty,
    output logic       full,
    output logic [1:0] occupancy
);

    beat_t      slot0;
    beat_t      slot1;
    logic [1:0] occ;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= push_beat;
                    else             slot1 <= push_beat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new beat lands behind whatever survives the pop.
                    if (occ == 2'd1) begin
                        slot0 <= push_beat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_beat = slot0;
    assign empty     = (occ == 2'd0);
    assign full      = (occ == 2'd2);
    assign occupancy = occ;

endmodule

// File: rtl/frame_pixel_sender.sv
// Reads one raster frame from synchronous RAM and streams it out with
// line/frame-end flags; a 2-entry skid FIFO covers the RAM read latency.
module frame_pixel_sender #(
    parameter int unsigned IMG_W  = img_pkg::IMG_W,
    parameter int unsigned IMG_H  = img_pkg::IMG_H,
    parameter int unsigned DATA_W = img_pkg::DATA_W,
    parameter int unsigned ADDR_W = img_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    frame_pixel_sender_if.master pix,
    output logic                busy,
    output logic                done
);

    localparam int unsigned       FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned       COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              line_end;
        logic              frame_end;
    } beat_t;

    img_pkg::state_t   state;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic              inflight;
    logic              inflight_le;
    logic              inflight_fe;
    beat_t             push_beat;
    beat_t             head_beat;
    logic              fifo_empty;
    logic              fifo_full;
    logic [1:0]        occ;
    logic              xfer;
    logic              at_limit;
    logic              rd_issue;

    // Occupancy plus the in-flight read may never exceed the two FIFO slots.
    assign at_limit  = fifo_full || ((occ == 2'd1) && inflight);
    assign xfer      = pix.pix_valid && pix.pix_ready;
    assign rd_issue  = (state == img_pkg::STREAM) && (!at_limit || xfer);
    assign mem_rd_en = rd_issue;
    assign mem_addr  = addr;

    assign push_beat = '{data: mem_rd_data, line_end: inflight_le, frame_end: inflight_fe};

    pix_skid_fifo #(
        .beat_t(beat_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_beat(push_beat),
        .pop      (xfer),
        .head_beat(head_beat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .occupancy(occ)
    );

    assign pix.pix_valid     = !fifo_empty;
    assign pix.pix_data      = head_beat.data;
    assign pix.pix_line_end  = head_beat.line_end;
    assign pix.pix_frame_end = head_beat.frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= img_pkg::IDLE;
            addr        <= '0;
            col         <= '0;
            inflight    <= 1'b0;
            inflight_le <= 1'b0;
            inflight_fe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            inflight <= rd_issue;
            done     <= 1'b0;
            if (rd_issue) begin
                inflight_le <= (col == LAST_COL);
                inflight_fe <= (addr == LAST_ADDR);
            end
            unique case (state)
                img_pkg::IDLE: begin
                    if (start) begin
                        state <= img_pkg::STREAM;
                        busy  <= 1'b1;
                        addr  <= '0;
                        col   <= '0;
                    end
                end
                img_pkg::STREAM: begin
                    if (rd_issue) begin
                        if (addr == LAST_ADDR) begin
                            state <= img_pkg::DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                            col  <= (col == LAST_COL) ? '0 : col + COL_W'(1);
                        end
                    end
                end
                img_pkg::DRAIN: begin
                    if (xfer && head_beat.frame_end) begin
                        state <= img_pkg::DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        addr  <= '0;
                    end
                end
                img_pkg::DONE: begin
                    state <= img_pkg::IDLE;
                end
                default: state <= img_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_pixel_sender.md
Name: frame_pixel_sender

Overview:
- Streaming transmitter that feeds the image-rotation datapath from a frame stored in synchronous RAM.
- On `start`, reads one IMG_W x IMG_H frame in raster order (address 0 upward) and emits it on a valid/ready pixel stream.
- Each pixel carries line-end and frame-end sideband flags.
- A 2-entry skid buffer absorbs the 1-cycle RAM read latency so that backpressure loses no pixels.

Parameters:
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame
- DATA_W, 8, pixel width in bits
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (clears on rst=0, independent of clk)
- start  in  1  one-cycle frame request; sampled only in IDLE
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, raster index row*IMG_W+col
- mem_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_rd_en
- pix_data  out  DATA_W  stream pixel
- pix_valid  out  1  stream valid
- pix_ready  in  1  downstream ready
- pix_line_end  out  1  current pixel is col IMG_W-1
- pix_frame_end  out  1  current pixel is the last of the frame
- busy  out  1  high from the cycle after start is accepted until the done pulse
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, pix_valid=0, pix_data=0, pix_line_end=0, pix_frame_end=0, busy=0, done=0. FIFO empty, in-flight flag clear, state IDLE.
- States and transitions:
  - IDLE -> STREAM when start=1.
  - STREAM -> DRAIN after the read of address IMG_W*IMG_H-1 is issued.
  - DRAIN -> DONE on the handshake of the frame_end pixel.
  - DONE -> IDLE unconditionally; done=1 during DONE only.
- Handshake: a transfer occurs when pix_valid && pix_ready on a rising edge.
  - Once pix_valid rises, it and pix_data/pix_line_end/pix_frame_end hold stable until the transfer.
  - pix_valid does not depend combinationally on pix_ready.
- Read issue rule: define count = FIFO occupancy + in-flight read (0/1). mem_rd_en=1 in STREAM when count<2, or when count==2 and a transfer occurs this cycle. The address increments after each issued read.
- Returned data is written to the FIFO tail with flags computed from the address it was read from.
  - line_end = (col==IMG_W-1).
  - frame_end = (index==IMG_W*IMG_H-1).
- Latency: start high at rising edge k -> mem_rd_en=1, mem_addr=0 in cycle k+1 -> first pix_valid=1 in cycle k+3.
- Throughput: with pix_ready held high, one pixel per cycle; IMG_W*IMG_H consecutive transfers.
- FIFO full (2 entries): no read is issued; an in-flight read is never dropped, which the count rule guarantees.
- Simultaneous FIFO push and pop: both occur and occupancy is unchanged.
- start while busy or in DONE: ignored, no restart or queueing.
- Reset mid-frame: everything returns to reset values immediately. Returning RAM data is discarded. The next start begins again from address 0.
- Address wrap: none. The counter stops at IMG_W*IMG_H-1 and mem_addr returns to 0 on entering DONE.

Decomposition:
- Shared package img_pkg holds:
  - IMG_W, IMG_H, DATA_W defaults
  - derived ADDR_W and FRAME_PIX = IMG_W*IMG_H
  - state typedef (IDLE, STREAM, DRAIN, DONE)
  - the pixel-beat struct {data, line_end, frame_end}
- One sub-module: pix_skid_fifo, a 2-entry register FIFO of pixel beats.
  - Ports: push, push_beat, pop, head_beat, empty, full, occupancy.
  - The parent handles address generation, the FSM and the count rule.

Test Plan:
- Reset: assert rst=0 for 3 cycles with start=1 -> all outputs 0, no mem_rd_en, state IDLE.
- Full frame, RAM preloaded mem[i]=i[7:0], pix_ready=1:
  - first pix_valid 3 cycles after start;
  - 65536 transfers with pix_data=i[7:0];
  - pix_line_end on transfers 255, 511, ..., 65535; pix_frame_end only on 65535;
  - done=1 one cycle after, busy=0 the same cycle.
- Backpressure: pix_ready low for 10 cycles at pixel 300, then random 50% toggling:
  - data/flags held stable while stalled;
  - mem_rd_en=0 while count==2;
  - output sequence identical to the previous test.
- Start during busy: pulse start at pixel 1000 -> no restart, exactly 65536 transfers, single done pulse.
- Reset mid-frame: rst=0 at pixel 1000 for 2 cycles while a read is in flight, then start -> first pixel is mem[0]=0x00 with no stale data.
- Small frame IMG_W=4, IMG_H=2, pix_ready=1 -> 8 transfers, line_end on beats 3 and 7, frame_end on beat 7, done on the next cycle.
